// File: rtl/twoscomp_arbiter.sv
// twoscomp_arbiter
// Shares one W-bit two's-complement negation unit among N requesters.
// Requests are granted round-robin whenever the response slot is free
// (empty, or full and being consumed this cycle). The granted operand is
// either negated or passed through and lands in a single registered
// response port with valid/ready handshaking.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [N]    per-requester request pending
//   req_data   [N*W]  requester i operand in bits [i*W +: W]
//   req_neg    [N]    per-requester: 1 = negate, 0 = pass through
//   req_ready  [N]    one-hot grant (zero when nothing is accepted)
//   rsp_valid         response register holds a result
//   rsp_data   [W]    result
//   rsp_id     [IDW]  index of the requester that produced the result
//   rsp_ovf           operand negated was the most-negative value
//   rsp_ready         consumer accepts the response this cycle
module twoscomp_arbiter #(
   parameter int N   = 4,
   parameter int W   = 8,
   parameter int IDW = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req_valid,
   input  logic [N*W-1:0] req_data,
   input  logic [N-1:0]   req_neg,
   output logic [N-1:0]   req_ready,
   output logic           rsp_valid,
   output logic [W-1:0]   rsp_data,
   output logic [IDW-1:0] rsp_id,
   output logic           rsp_ovf,
   input  logic           rsp_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam int unsigned NU       = N;
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;

   logic           slot_free;
   logic           gnt_any;
   logic [IDW-1:0] gnt_idx;
   logic [IDW-1:0] scan_idx;
   logic [N-1:0]   gnt_vec;

   logic [W-1:0]   opnd;
   logic [W-1:0]   res_d;
   logic           ovf_d;

   // A full slot that is being consumed this cycle can be refilled on the same edge.
   assign slot_free = (state_q == EMPTY) || rsp_ready;

   // Round-robin search starting at ptr, wrapping modulo N.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      gnt_vec  = '0;
      if (slot_free) begin
         for (int unsigned k = 0; k < NU; k++) begin
            scan_idx = IDW'((k + 32'(ptr_q)) % NU);
            if (!gnt_any && req_valid[scan_idx]) begin
               gnt_any = 1'b1;
               gnt_idx = scan_idx;
            end
         end
      end
      if (gnt_any) begin
         gnt_vec[gnt_idx] = 1'b1;
      end
   end

   // Gated by rst_n so no grant is advertised while reset is held.
   assign req_ready = rst_n ? gnt_vec : '0;

   // ~d + 1 already wraps the most-negative value onto itself; ovf flags that case.
   always_comb begin
      opnd  = req_data[32'(gnt_idx) * W +: W];
      res_d = opnd;
      ovf_d = 1'b0;
      if (req_neg[gnt_idx]) begin
         res_d = ~opnd + W'(1);
         ovf_d = (opnd == MOST_NEG);
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (gnt_any) begin
         state_d = FULL;
         ptr_d   = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end else if ((state_q == FULL) && rsp_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         ptr_q    <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
         rsp_ovf  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (gnt_any) begin
            rsp_data <= res_d;
            rsp_id   <= gnt_idx;
            rsp_ovf  <= ovf_d;
         end
      end
   end

   assign rsp_valid = (state_q == FULL);

endmodule

// File: tb/tb_twoscomp_arbiter.sv
// Self-checking bench for twoscomp_arbiter (N=4, W=8).
// A behavioural model tracks the response slot and round-robin pointer as
// plain integers; directed steps cover reset, edge operands, fairness,
// sparse requests, backpressure and drain, followed by a random phase.
module tb_twoscomp_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_neg;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_ovf;
   logic        rsp_ready;

   int checks = 0;
   int fails  = 0;

   // reference model state
   bit m_valid;
   int m_data;
   int m_id;
   bit m_ovf;
   int m_ptr;

   twoscomp_arbiter #(.N(4), .W(8), .IDW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_neg   (req_neg),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ovf   (rsp_ovf),
      .rsp_ready (rsp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = 0;
      m_id    = 0;
      m_ovf   = 1'b0;
      m_ptr   = 0;
   endtask

   function automatic int exp_grant();
      if (m_valid && !rsp_ready) return -1;
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (m_ptr + k) % 4;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic put(input int idx, input int d, input bit neg);
      req_valid = 4'(1 << idx);
      req_data[8*idx +: 8] = 8'(d);
      req_neg[idx] = neg;
   endtask

   // One clock: check grant against the model, step the model at the edge,
   // then check the registered response.
   task automatic cycle(input string tag);
      int g;
      int d;
      #1;
      g = exp_grant();
      chk({tag, "/req_ready"}, 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      @(posedge clk);
      if (g >= 0) begin
         d = int'((req_data >> (8 * g)) & 32'hFF);
         if (req_neg[g]) begin
            m_data = (256 - d) % 256;
            m_ovf  = (d == 128);
         end else begin
            m_data = d;
            m_ovf  = 1'b0;
         end
         m_id    = g;
         m_valid = 1'b1;
         m_ptr   = (g + 1) % 4;
      end else if (rsp_ready) begin
         m_valid = 1'b0;
      end
      #1;
      chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'(m_valid));
      chk({tag, "/rsp_data"},  32'(rsp_data),  32'(m_data));
      chk({tag, "/rsp_id"},    32'(rsp_id),    32'(m_id));
      chk({tag, "/rsp_ovf"},   32'(rsp_ovf),   32'(m_ovf));
   endtask

   int exp_rr[6]     = '{0, 1, 2, 3, 0, 1};
   int exp_sparse[7] = '{3, 1, 3, 1, 1, 1, 1};

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      req_data  = '0;
      req_neg   = '0;
      rsp_ready = 1'b0;
      model_reset();

      // reset values while held
      #3;
      chk("rst/req_ready", 32'(req_ready), 32'd0);
      chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst/rsp_data",  32'(rsp_data),  32'd0);
      chk("rst/rsp_id",    32'(rsp_id),    32'd0);
      chk("rst/rsp_ovf",   32'(rsp_ovf),   32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // put a response in flight, then reset asynchronously mid-cycle
      req_valid = '0;
      put(3, 8'h42, 1'b0);
      rsp_ready = 1'b0;
      cycle("prefill");
      chk("prefill/data", 32'(rsp_data), 32'h42);
      req_valid = '1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst/req_ready", 32'(req_ready), 32'd0);
      chk("midrst/rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst/rsp_data",  32'(rsp_data),  32'd0);
      chk("midrst/rsp_id",    32'(rsp_id),    32'd0);
      chk("midrst/rsp_ovf",   32'(rsp_ovf),   32'd0);
      model_reset();
      req_valid = '0;
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // requester 2 negates 0x05
      rsp_ready = 1'b1;
      put(2, 8'h05, 1'b1);
      cycle("neg05");
      chk("neg05/data", 32'(rsp_data), 32'hFB);
      chk("neg05/id",   32'(rsp_id),   32'd2);
      chk("neg05/ovf",  32'(rsp_ovf),  32'd0);

      // edge operands
      put(0, 8'h80, 1'b1);
      cycle("neg80");
      chk("neg80/data", 32'(rsp_data), 32'h80);
      chk("neg80/ovf",  32'(rsp_ovf),  32'd1);
      put(1, 8'h00, 1'b1);
      cycle("neg00");
      chk("neg00/data", 32'(rsp_data), 32'h00);
      chk("neg00/ovf",  32'(rsp_ovf),  32'd0);
      put(3, 8'h7F, 1'b0);
      cycle("pass7f");
      chk("pass7f/data", 32'(rsp_data), 32'h7F);
      chk("pass7f/ovf",  32'(rsp_ovf),  32'd0);
      put(3, 8'h7F, 1'b1);
      cycle("neg7f");
      chk("neg7f/data", 32'(rsp_data), 32'h81);
      chk("neg7f/ovf",  32'(rsp_ovf),  32'd0);

      // round-robin with everyone requesting (pointer is at 0 here)
      req_valid = '1;
      req_data  = 32'hA1B2C3D4;
      req_neg   = 4'b0101;
      for (int i = 0; i < 6; i++) begin
         cycle("rr");
         chk("rr/id",    32'(rsp_id),    32'(exp_rr[i]));
         chk("rr/valid", 32'(rsp_valid), 32'd1);
      end

      // sparse: pointer is at 2, only 1 and 3 pending, then only 1
      for (int i = 0; i < 7; i++) begin
         req_valid = (i < 4) ? 4'b1010 : 4'b0010;
         cycle("sparse");
         chk("sparse/id", 32'(rsp_id), 32'(exp_sparse[i]));
      end

      // backpressure with id 1 / 0xFF held, req2 waiting
      put(1, 8'h01, 1'b1);
      cycle("bp_load");
      chk("bp_load/data", 32'(rsp_data), 32'hFF);
      rsp_ready = 1'b0;
      put(2, 8'h10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle("bp_hold");
         chk("bp_hold/req_ready", 32'(req_ready), 32'd0);
         chk("bp_hold/data",      32'(rsp_data),  32'hFF);
         chk("bp_hold/id",        32'(rsp_id),    32'd1);
         chk("bp_hold/valid",     32'(rsp_valid), 32'd1);
      end
      rsp_ready = 1'b1;
      cycle("bp_swap");
      chk("bp_swap/valid", 32'(rsp_valid), 32'd1);
      chk("bp_swap/id",    32'(rsp_id),    32'd2);
      chk("bp_swap/data",  32'(rsp_data),  32'h10);

      // drain
      req_valid = '0;
      cycle("drain");
      chk("drain/valid", 32'(rsp_valid), 32'd0);
      chk("drain/data",  32'(rsp_data),  32'h10);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         req_valid = 4'($urandom);
         req_data  = $urandom;
         req_neg   = 4'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) req_data[7:0] = 8'h80;
         cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
